// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit owning HI/LO; define MD_MADD_EN for madd/maddu/msub/msubu.
// Latency: Busy high MULT_LAT (multiply class) or DIV_LAT (divide) cycles; HI/LO update as Busy falls.
// Backpressure: none queued; Start and HiLoWE are dropped while Busy, the hazard unit stalls on Busy.
module md_unit #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        HiLoWE,
    input  logic        HiLoSel,
    input  logic [31:0] WD,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    op_q, op_d;
    logic [31:0]   a_q, a_d, b_q, b_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;

    logic          op_ok, op_is_div;
    logic          op_signed;
    logic [63:0]   a_ext, b_ext, prod;
    logic          a_neg, b_neg;
    logic [31:0]   a_mag, b_mag, den, q_mag, r_mag, quot, rem;
    logic          res_we;
    logic [63:0]   res;

`ifdef MD_MADD_EN
    assign op_ok = 1'b1;
`else
    assign op_ok = ~MDOp[2];
`endif
    assign op_is_div = (MDOp[2:1] == 2'b01);

    // Even opcodes are the signed variants in both the mult and madd groups.
    assign op_signed = ~op_q[0];
    assign a_ext     = {{32{op_signed & a_q[31]}}, a_q};
    assign b_ext     = {{32{op_signed & b_q[31]}}, b_q};
    assign prod      = a_ext * b_ext;

    // Divide on magnitudes, then restore signs; 0x80000000/-1 falls out as 0x80000000 naturally.
    // Operands are held for the whole busy period, so the divider is a multicycle path.
    assign a_neg = op_signed & a_q[31];
    assign b_neg = op_signed & b_q[31];
    assign a_mag = a_neg ? (~a_q + 32'd1) : a_q;
    assign b_mag = b_neg ? (~b_q + 32'd1) : b_q;
    assign den   = (b_q == 32'd0) ? 32'd1 : b_mag;
    assign q_mag = a_mag / den;
    assign r_mag = a_mag % den;
    assign quot  = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign rem   = a_neg ? (~r_mag + 32'd1) : r_mag;

    always_comb begin
        res_we = 1'b0;
        res    = prod;
        case (op_q)
            3'd0, 3'd1: res_we = 1'b1;
            3'd2, 3'd3: begin
                res_we = (b_q != 32'd0);
                res    = {rem, quot};
            end
`ifdef MD_MADD_EN
            // HI/LO cannot change while busy, so they still equal the accumulator base.
            3'd4, 3'd5: begin
                res_we = 1'b1;
                res    = {hi_q, lo_q} + prod;
            end
            3'd6, 3'd7: begin
                res_we = 1'b1;
                res    = {hi_q, lo_q} - prod;
            end
`endif
            default: res_we = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                // Start has priority over an mthi/mtlo strobe even when its opcode is ignored.
                if (Start) begin
                    if (op_ok) begin
                        state_d = S_RUN;
                        cnt_d   = op_is_div ? CW'(DIV_LAT) : CW'(MULT_LAT);
                        op_d    = MDOp;
                        a_d     = A;
                        b_d     = B;
                    end
                end else if (HiLoWE) begin
                    if (HiLoSel) hi_d = WD;
                    else         lo_d = WD;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                    if (res_we) begin
                        hi_d = res[63:32];
                        lo_d = res[31:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign Busy = (state_q == S_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: issued operations push expected HI/LO and busy length; a monitor checks on Busy fall.
module tb_md_unit;
    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk;
    logic        reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A, B;
    logic        HiLoWE, HiLoSel;
    logic [31:0] WD;
    logic        Busy;
    logic [31:0] HI, LO;

    md_unit #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
        .HiLoWE(HiLoWE), .HiLoSel(HiLoSel), .WD(WD), .Busy(Busy), .HI(HI), .LO(LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    int          vectors = 0;
    int          miscompares = 0;
    logic [31:0] ref_hi = 32'd0;
    logic [31:0] ref_lo = 32'd0;
    bit          mon_en = 1'b0;
    bit          prev_busy = 1'b0;
    int          busy_cyc = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endfunction

    // Architectural reference: plain 64-bit arithmetic on the operands.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi, input logic [31:0] lo,
                         output bit ok, output logic [31:0] nh, output logic [31:0] nl, output int lat);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub;
`ifdef MD_MADD_EN
        logic [63:0] p, acc;
`endif
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ok  = 1'b1;
        nh  = hi;
        nl  = lo;
        lat = MULT_LAT;
        case (op)
            3'd0: {nh, nl} = sa * sb;
            3'd1: {nh, nl} = ua * ub;
            3'd2, 3'd3: begin
                lat = DIV_LAT;
                if (b != 32'd0) begin
                    if (op == 3'd2) begin
                        q  = sa / sb;
                        r  = sa % sb;
                        nl = q[31:0];
                        nh = r[31:0];
                    end else begin
                        nl = a / b;
                        nh = a % b;
                    end
                end
            end
            default: begin
`ifdef MD_MADD_EN
                p   = op[0] ? ua * ub : 64'(sa * sb);
                acc = op[1] ? {hi, lo} - p : {hi, lo} + p;
                {nh, nl} = acc;
`else
                ok = 1'b0;
`endif
            end
        endcase
    endtask

    always @(posedge clk) begin
        #1;
        if (!mon_en || reset) begin
            prev_busy = 1'b0;
            busy_cyc  = 0;
        end else begin
            if (Busy) begin
                busy_cyc++;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL busy_unexpected: got Busy=1, expected 0");
                end else begin
                    check("hold_hi", HI, exp_q[0].pre_hi);
                    check("hold_lo", LO, exp_q[0].pre_lo);
                end
            end else if (prev_busy) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL done_unexpected: got completion, expected none pending");
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("result_hi", HI, e.hi);
                    check("result_lo", LO, e.lo);
                    check("busy_len", busy_cyc, e.lat);
                end
                busy_cyc = 0;
            end
            prev_busy = Busy;
        end
    end

    task automatic wait_idle();
        int n = 0;
        while ((Busy || exp_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            vectors++;
            miscompares++;
            $display("FAIL timeout: busy=%b pending=%0d, expected idle", Busy, exp_q.size());
            exp_q.delete();
        end
        check("idle_hi", HI, ref_hi);
        check("idle_lo", LO, ref_lo);
    endtask

    task automatic mt(input bit sel, input logic [31:0] d);
        @(negedge clk);
        HiLoWE = 1'b1; HiLoSel = sel; WD = d;
        @(negedge clk);
        HiLoWE = 1'b0;
        if (sel) ref_hi = d;
        else     ref_lo = d;
        check("mt_hi", HI, ref_hi);
        check("mt_lo", LO, ref_lo);
    endtask

    // with_we: same-cycle mthi/mtlo strobe; poke: second Start plus HiLoWE mid-operation.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit with_we, input bit poke);
        bit          ok;
        logic [31:0] nh, nl;
        int          lat;
        exp_t        e;
        model(op, a, b, ref_hi, ref_lo, ok, nh, nl, lat);
        @(negedge clk);
        Start = 1'b1; MDOp = op; A = a; B = b;
        HiLoWE = with_we; HiLoSel = 1'($urandom_range(0, 1)); WD = $urandom;
        if (ok) begin
            e = '{ref_hi, ref_lo, nh, nl, lat};
            exp_q.push_back(e);
            ref_hi = nh;
            ref_lo = nl;
        end
        @(negedge clk);
        Start = 1'b0; HiLoWE = 1'b0;
        if (!ok) begin
            check("noop_busy", {31'd0, Busy}, 32'd0);
            check("noop_hi", HI, ref_hi);
            check("noop_lo", LO, ref_lo);
        end else begin
            if (poke && lat > 2) begin
                @(negedge clk);
                Start = 1'b1; MDOp = 3'($urandom_range(0, 7)); A = $urandom; B = $urandom;
                HiLoWE = 1'b1; WD = $urandom;
                @(negedge clk);
                Start = 1'b0; HiLoWE = 1'b0;
            end
            wait_idle();
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset = 1'b1; Start = 1'b0; MDOp = 3'd0; A = 32'd0; B = 32'd0;
        HiLoWE = 1'b0; HiLoSel = 1'b0; WD = 32'd0;
        #3;
        check("rst_busy", {31'd0, Busy}, 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;

        issue(3'd0, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        check("tp_mult_hi", HI, 32'hFFFF_FFFF);
        check("tp_mult_lo", LO, 32'hFFFF_FFFE);
        issue(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
        check("tp_multu_hi", HI, 32'h0000_0001);
        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        check("tp_div_lo", LO, 32'hFFFF_FFFD);
        check("tp_div_hi", HI, 32'hFFFF_FFFF);
        issue(3'd3, 32'd7, 32'd0, 1'b0, 1'b0);
        check("tp_divz_lo", LO, 32'hFFFF_FFFD);
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        check("tp_divovf_lo", LO, 32'h8000_0000);
        check("tp_divovf_hi", HI, 32'd0);

        mt(1'b0, 32'h1234);
        mt(1'b1, 32'h5678);
        issue(3'd0, 32'd3, 32'd4, 1'b1, 1'b1);
        check("tp_m34_hi", HI, 32'd0);
        check("tp_m34_lo", LO, 32'hC);

        mt(1'b1, 32'd0);
        mt(1'b0, 32'hFFFF_FFFF);
        issue(3'd5, 32'd1, 32'd1, 1'b0, 1'b0);
`ifdef MD_MADD_EN
        check("tp_maddu_hi", HI, 32'd1);
        check("tp_maddu_lo", LO, 32'd0);
`else
        check("tp_maddu_hi", HI, 32'd0);
        check("tp_maddu_lo", LO, 32'hFFFF_FFFF);
`endif

        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 9);
            if (k < 2) mt(1'($urandom_range(0, 1)), $urandom);
            else issue(3'($urandom_range(0, 7)), pick(), pick(),
                       ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end

        // Reset in the fourth busy cycle of a divide must clear everything at once.
        mon_en = 1'b0;
        @(negedge clk);
        Start = 1'b1; MDOp = 3'd2; A = 32'd100; B = 32'd7;
        @(negedge clk);
        Start = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_busy_before", {31'd0, Busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_busy", {31'd0, Busy}, 32'd0);
        check("rst_mid_hi", HI, 32'd0);
        check("rst_mid_lo", LO, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        ref_hi = 32'd0;
        ref_lo = 32'd0;
        exp_q.delete();
        repeat (DIV_LAT + 3) @(negedge clk);
        check("post_rst_busy", {31'd0, Busy}, 32'd0);
        check("post_rst_hi", HI, 32'd0);
        check("post_rst_lo", LO, 32'd0);
        mon_en = 1'b1;
        issue(3'd1, 32'h0001_0000, 32'h0003_0000, 1'b0, 1'b0);
        issue(3'd2, 32'd100, 32'hFFFF_FFF9, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
